// File: rtl/counter_case02_pkg.sv
// Shared types and defaults for the gated reference event/time counter.
package counter_case02_pkg;

    localparam int COUNT_W_DEF   = 8;
    localparam int COUNT_MAX_DEF = (2 ** COUNT_W_DEF) - 1;

    typedef logic [COUNT_W_DEF-1:0] count_t;

    // Unsigned modulo (max+1) successor; wraps to zero after the terminal count.
    function automatic count_t count_next(input count_t cur, input count_t max_val);
        count_t nxt;
        if (cur == max_val) begin
            nxt = '0;
        end else begin
            nxt = cur + count_t'(1);
        end
        return nxt;
    endfunction

endpackage : counter_case02_pkg

// File: rtl/counter_case02_if.sv
// Control/status bundle of the gated counter: gate enable and count qualifier
// in, current count and terminal-count pulse out.
interface counter_case02_if
    import counter_case02_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);

    logic               i_clk_en;
    logic               i_count_valid;
    logic               o_count_end;
    logic [COUNT_W-1:0] o_count;

    // Side that drives the controls and watches the count (e.g. a sequencer).
    modport master (
        output i_clk_en,
        output i_count_valid,
        input  o_count_end,
        input  o_count
    );

    // The counter itself.
    modport slave (
        input  i_clk_en,
        input  i_count_valid,
        output o_count_end,
        output o_count
    );

endinterface : counter_case02_if

// File: rtl/counter_case02_clk_gate_cell.sv
// Latch-based integrated clock gate. This is the only latch in the block; when
// a library ICG cell is available, replace the body with an instance of it
// keeping the same clk/en/gclk ports.
module clk_gate_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic r_en_q;

    // Enable latch, transparent while clk is low so en_q is stable for the whole high phase.
    always_latch begin
        if (!clk) begin
            r_en_q <= en;
        end
    end

    assign gclk = clk & r_en_q;

endmodule : clk_gate_cell

// File: rtl/counter_case02.sv
// Free-running up-counter on a gated clock with a per-cycle count qualifier.
// Produces the current count and a one-gated-cycle pulse on wrap to zero.
module counter_case02
    import counter_case02_pkg::*;
#(
    parameter int COUNT_W   = COUNT_W_DEF,
    parameter int COUNT_MAX = (2 ** COUNT_W) - 1
) (
    input  logic              clk,
    input  logic              resetn,
    counter_case02_if.slave   bus
);

    localparam logic [COUNT_W-1:0] LP_MAX = COUNT_MAX[COUNT_W-1:0];
    localparam logic [COUNT_W-1:0] LP_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic               w_gclk;
    logic [COUNT_W-1:0] r_count;
    logic               r_count_end;
    logic               w_at_max;

    clk_gate_cell u_clk_gate (
        .clk  (clk),
        .en   (bus.i_clk_en),
        .gclk (w_gclk)
    );

    assign w_at_max = (r_count == LP_MAX);

    // Count and terminal-count pulse; reset is asynchronous so it clears even with the gate closed.
    always_ff @(posedge w_gclk or negedge resetn) begin
        if (!resetn) begin
            r_count     <= '0;
            r_count_end <= 1'b0;
        end else if (bus.i_count_valid) begin
            if (w_at_max) begin
                r_count     <= '0;
                r_count_end <= 1'b1;
            end else begin
                r_count     <= r_count + LP_ONE;
                r_count_end <= 1'b0;
            end
        end else begin
            r_count_end <= 1'b0;
        end
    end

    assign bus.o_count     = r_count;
    assign bus.o_count_end = r_count_end;

endmodule : counter_case02

// File: tb/tb_counter_case02.sv
module tb_counter_case02;

    logic clk;
    logic resetn;

    counter_case02_if bus ();

    counter_case02 dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: count value and last terminal-count flag.
    int m_cnt = 0;
    int m_end = 0;

    typedef struct {
        logic en;
        logic valid;
        int   exp_count;
        int   exp_end;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive at a falling edge, model the rising edge, compare at the next falling edge.
    task automatic cycle(input logic en, input logic v);
        bus.i_clk_en      = en;
        bus.i_count_valid = v;
        @(posedge clk);
        if (resetn && en) begin
            if (v) begin
                m_end = (m_cnt == 255) ? 1 : 0;
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_end = 0;
            end
        end
        @(negedge clk);
        chk("count", int'(bus.o_count), m_cnt);
        chk("count_end", int'(bus.o_count_end), m_end);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 2, 0};
        vecs[4] = '{1'b0, 1'b1, 2, 0};
        vecs[5] = '{1'b1, 1'b0, 2, 0};
        vecs[6] = '{1'b1, 1'b1, 3, 0};
        vecs[7] = '{1'b0, 1'b0, 3, 0};

        resetn            = 1'b1;
        bus.i_clk_en      = 1'b0;
        bus.i_count_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("reset_count", int'(bus.o_count), 0);
        chk("reset_end", int'(bus.o_count_end), 0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold_count", int'(bus.o_count), 0);
            chk("reset_hold_end", int'(bus.o_count_end), 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        m_cnt = 0;
        m_end = 0;

        // Released with gate off: nothing moves even with valid high.
        repeat (3) cycle(1'b0, 1'b1);
        chk("gate_off_after_reset", int'(bus.o_count), 0);

        // Gate on, valid off.
        repeat (50) cycle(1'b1, 1'b0);
        chk("gate_on_valid_off", int'(bus.o_count), 0);

        // Table-driven short sequence.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].en, vecs[i].valid);
            chk($sformatf("vec%0d_count", i), int'(bus.o_count), vecs[i].exp_count);
            chk($sformatf("vec%0d_end", i), int'(bus.o_count_end), vecs[i].exp_end);
        end

        // Back to zero via a reset pulse between edges.
        resetn = 1'b0;
        #1;
        m_cnt = 0;
        m_end = 0;
        chk("pulse_reset_count", int'(bus.o_count), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Counting and stall: 50 on, 20 stalled, 100 on.
        repeat (50) cycle(1'b1, 1'b1);
        chk("burst1", int'(bus.o_count), 'h32);
        repeat (20) cycle(1'b1, 1'b0);
        chk("stall", int'(bus.o_count), 'h32);
        repeat (100) cycle(1'b1, 1'b1);
        chk("burst2", int'(bus.o_count), 'h96);

        // Wrap.
        repeat (104) cycle(1'b1, 1'b1);
        chk("pre_wrap", int'(bus.o_count), 'hFE);
        chk("pre_wrap_end", int'(bus.o_count_end), 0);
        cycle(1'b1, 1'b1);
        chk("wrap_ff", int'(bus.o_count), 'hFF);
        chk("wrap_ff_end", int'(bus.o_count_end), 0);
        cycle(1'b1, 1'b1);
        chk("wrap_00", int'(bus.o_count), 'h00);
        chk("wrap_00_end", int'(bus.o_count_end), 1);
        // Gate closed with the pulse pending: it must stay frozen high.
        repeat (3) cycle(1'b0, 1'b1);
        chk("frozen_end", int'(bus.o_count_end), 1);
        chk("frozen_count", int'(bus.o_count), 'h00);
        cycle(1'b1, 1'b1);
        chk("wrap_01", int'(bus.o_count), 'h01);
        chk("wrap_01_end", int'(bus.o_count_end), 0);

        // Gate off mid-count, resume at value+1.
        repeat (15) cycle(1'b1, 1'b1);
        chk("pre_gate_off", int'(bus.o_count), 'h10);
        repeat (5) cycle(1'b0, 1'b1);
        chk("gate_off_freeze", int'(bus.o_count), 'h10);
        cycle(1'b1, 1'b1);
        chk("gate_resume", int'(bus.o_count), 'h11);

        // Async reset at 0x80, asserted between edges.
        repeat (111) cycle(1'b1, 1'b1);
        chk("at_0x80", int'(bus.o_count), 'h80);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_count", int'(bus.o_count), 0);
        chk("async_rst_end", int'(bus.o_count_end), 0);
        m_cnt = 0;
        m_end = 0;
        @(negedge clk);
        chk("async_rst_hold", int'(bus.o_count), 0);
        resetn = 1'b1;
        cycle(1'b1, 1'b0);
        chk("restart_idle", int'(bus.o_count), 0);
        cycle(1'b1, 1'b1);
        chk("restart_first", int'(bus.o_count), 1);

        // Randomized against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                resetn = 1'b0;
                #1;
                m_cnt = 0;
                m_end = 0;
                chk("rand_rst_count", int'(bus.o_count), 0);
                chk("rand_rst_end", int'(bus.o_count_end), 0);
                @(negedge clk);
                resetn = 1'b1;
            end else begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_counter_case02

// File: doc/counter_case02.md
# counter_case02

Free-running-clock 8-bit up-counter with an integrated clock gate and a per-cycle count-valid qualifier. The gate stops the counter's clock entirely when counting is not needed, for power saving. The count-valid input stalls counting on an otherwise running clock. It is a leaf block used as a reference event/time counter. It reports its current count and a one-cycle terminal-count pulse on wrap.

## Interface
- COUNT_W, 8, counter width in bits
- COUNT_MAX, 2**COUNT_W-1 (8'hFF), terminal count; the counter wraps to 0 after it
- clk  input  1  free-running clock; all state updates on rising edges of the gated clock
- resetn  input  1  reset, asynchronous, active-low; acts regardless of gate state
- i_clk_en  input  1  clock-gate enable; 0 stops the internal gated clock
- i_count_valid  input  1  count qualifier; sampled on gated rising edges
- o_count_end  output  1  registered terminal-count pulse
- o_count  output  COUNT_W  registered current count

## Operation
- Reset (resetn=0): o_count=0 and o_count_end=0 immediately, without waiting for a clock edge. Both hold these values until resetn=1 and a gated edge occurs.
- Gated clock: gclk = clk AND en_q. en_q is i_clk_en captured by a latch that is transparent while clk=0. This gives a glitch-free gated clock.
- On each gclk rising edge with i_count_valid=1:
  - o_count < COUNT_MAX: o_count <= o_count+1, and o_count_end <= 0.
  - o_count == COUNT_MAX: o_count <= 0, and o_count_end <= 1.
- On each gclk rising edge with i_count_valid=0: o_count holds and o_count_end <= 0.
- Gate off (en_q=0): no gclk edges, so o_count and o_count_end both freeze at their current values. A pending o_count_end=1 stays high until the next gated edge.
- Arithmetic: unsigned modulo (COUNT_MAX+1). If COUNT_MAX < 2**COUNT_W-1, values above COUNT_MAX are unreachable.

## Timing
- i_clk_en setup: it must be stable while clk is low. A change during clk low takes effect at the next rising clk edge. A change during clk high takes effect one rising edge later.
- Increment latency: o_count updates at the same gated rising edge that samples i_count_valid=1.
- o_count_end:
  - goes high at the edge where o_count goes COUNT_MAX to 0;
  - with valid held high, it is high for exactly one gated cycle;
  - it falls at the next gated edge.
- Valid low for N gated cycles causes a stall of exactly N cycles, with no lost or extra counts.
- Reset mid-count: outputs clear asynchronously. Counting restarts from 0 at the first gated edge with valid=1 after resetn deasserts. Deassertion must meet recovery time relative to clk.
- Simultaneous gate-on and valid-on: the first counted edge is the first rising edge where en_q=1.

## Structure
- Shared package counter_case02_pkg:
  - localparam COUNT_W_DEF = 8;
  - localparam COUNT_MAX_DEF;
  - typedef count_t, a logic vector of COUNT_W_DEF bits.
- Sub-module clk_gate_cell:
  - a latch-based ICG with ports clk, en, gclk;
  - wraps a library ICG cell when one is available;
  - it is the only place the latch lives.
- Top-level counter_case02 contains the instance of clk_gate_cell, the count register, and the end-flag register.

## Test plan
- Reset and hold:
  - stimulus: resetn=0 for 20 ns with i_clk_en=0 and i_count_valid=0;
  - required: o_count=0x00 and o_count_end=0 throughout;
  - then release reset with the gate still off: o_count stays 0x00.
- Gate on, valid off:
  - stimulus: i_clk_en=1 with i_count_valid=0 for 50 cycles;
  - required: o_count stays 0x00.
- Counting and stall:
  - stimulus: valid=1 for 50 cycles, then 0 for 20 cycles, then 1 for 100 cycles;
  - required: o_count=0x32 after the first burst, holds 0x32 during the stall, and ends at 0x96.
- Wrap:
  - stimulus: hold valid=1 from 0xFE;
  - required: the sequence is 0xFE, 0xFF, 0x00, 0x01;
  - o_count_end=1 only while o_count=0x00 directly after the wrap.
- Gate off mid-count:
  - stimulus: drop i_clk_en to 0 with valid=1;
  - required: o_count freezes at its current value;
  - after re-enabling, counting resumes at value+1 with no skipped or repeated values.
- Async reset mid-count:
  - stimulus: resetn=0 at o_count=0x80, asserted between clock edges;
  - required: o_count=0x00 immediately and o_count_end=0.
